seg7_pattern_encoder: RTL and testbench
=======================================

// Module: seg7_pattern_encoder
// PURPOSE
//  Converts a 7-bit active-low segment pattern (bit0=a .. bit6=g) back into a 4-bit hex digit.
//  Emits each new, stable, non-blank pattern once over a valid/ready handshake.
//  Used to capture digits from segment-driven sources (player panel, second board) into game logic.
//  Glitch-filtered; flags patterns outside the 16-digit table.
// PARAMETERS
//  STABLE_CYCLES  4  consecutive unchanged cycles required before a pattern is accepted (>=1)
//  CNT_W          3  stability counter width; must hold STABLE_CYCLES
// PORTS
//  clk          in   1  system clock, rising edge
//  resetn       in   1  asynchronous active-low reset
//  seg_in       in   7  active-low segment pattern, bit0=a .. bit6=g
//  out_ready    in   1  consumer accepts digit when high with out_valid
//  out_valid    out  1  digit available; held until accepted
//  out_hex      out  4  decoded digit value
//  out_illegal  out  1  pattern not in table; out_hex=4'h0 when set
//  busy         out  1  high whenever state != S_IDLE
// BEHAVIOUR
//  Reset (async, resetn=0): out_valid=0, out_hex=0, out_illegal=0, busy=0.
//    Also seg_q=7'h7F, cnt=0, last_pat=7'h7F (blank), state=S_IDLE.
//  Sampling: seg_q<=seg_in every edge.
//  Counter: cnt<=0 if seg_in!=seg_q; else cnt<=cnt+1, saturating at STABLE_CYCLES.
//  stable = (cnt==STABLE_CYCLES).
//  Table: 0:1000000 1:1111001 2:0100100 3:0110000 4:0011001 5:0010010 6:0000010 7:1111000
//         8:0000000 9:0011000 A:0001000 b:0000011 C:1000110 d:0100001 E:0000110 F:0001110
//  Blank = 7'b1111111; any other pattern is illegal.
//  FSM S_IDLE:
//    stable && seg_q==blank          -> last_pat<=blank, stay.
//    stable && seg_q!=blank && seg_q!=last_pat
//                                    -> latch out_hex/out_illegal, last_pat<=seg_q, out_valid<=1, go S_VALID.
//  FSM S_VALID: out_valid, out_hex, out_illegal frozen; seg_in changes ignored for output.
//    out_ready=1 -> out_valid<=0, go S_IDLE. Counter keeps running during S_VALID.
//  Latency: seg_in change before edge 0, then held -> out_valid high after edge STABLE_CYCLES+1
//    (6 edges for default).
//  Pattern held indefinitely -> exactly one emission. Same digit re-emits only after blank is stable.
//  New pattern stable during S_VALID -> emitted on the cycle after handshake (returns to S_IDLE first).
//  Pattern unstable (<STABLE_CYCLES+1 edges) -> never emitted.
//  out_ready high with out_valid low -> no effect.
//  Reset mid-S_VALID -> out_valid drops asynchronously; the digit is lost.
//  Illegal patterns update last_pat like legal ones: each illegal pattern is flagged once.
// CONFIGURATION
//  SEG7_ENC_SYNC_EN defined:
//    seg_in passes a 2-flop synchronizer (reset 7'h7F) before seg_q.
//    Latency +2 cycles (8 edges default). Required for asynchronous/off-board sources.
//  SEG7_ENC_SYNC_EN undefined:
//    seg_in is synchronous to clk. No synchronizer; latency as above.
// STRUCTURE
//  Package seg7_pkg: SEG_BLANK; the 16 digit pattern constants (shared with the hex display
//    driver, single source of truth); state encoding S_IDLE=1'b0, S_VALID=1'b1.
//  Sub-module seg7_stability_filter (params STABLE_CYCLES, CNT_W; ports clk, resetn, din[6:0],
//    dout[6:0], stable). Holds the optional synchronizer, seg_q and cnt.
//  Top: table lookup (combinational case) + FSM + output registers.
// TESTING
//  1 Hold 7'b0110000 for 12 cycles, ready=1 -> out_valid for 1 cycle at edge 6, out_hex=3, illegal=0, one emission.
//  2 Hold 7'b0010010 3 cycles then 7'b1111000 held -> no '5' emitted; out_hex=7 at edge 6 after the change.
//  3 Emit '3' with ready=0 for 20 cycles; seg_in -> 7'b1111000 meanwhile
//      -> out_hex stays 3, valid stays high; on ready '3' accepted, then '7' valid one cycle later.
//  4 '5' held, blank held 5 cycles, '5' again -> two emissions of 4'h5; '5' held 50 cycles -> one.
//  5 Hold 7'b1010101 -> out_valid=1, out_illegal=1, out_hex=0.
//  6 resetn=0 while out_valid=1 -> out_valid=0 immediately without a clock edge; after release, busy=0, no stale emission.
//    Repeat tests 1 and 5 with SEG7_ENC_SYNC_EN defined: latency is 8 edges.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared seven-segment constants: blank pattern, the 16 hex digit patterns
// (active-low, bit0=a .. bit6=g) and the encoder state encoding.
package seg7_pkg;

  localparam int unsigned SEG_W = 7;
  localparam int unsigned HEX_W = 4;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  localparam logic [SEG_W-1:0] SEG_0 = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1 = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2 = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3 = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4 = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5 = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6 = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7 = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8 = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9 = 7'b0011000;
  localparam logic [SEG_W-1:0] SEG_A = 7'b0001000;
  localparam logic [SEG_W-1:0] SEG_B = 7'b0000011;
  localparam logic [SEG_W-1:0] SEG_C = 7'b1000110;
  localparam logic [SEG_W-1:0] SEG_D = 7'b0100001;
  localparam logic [SEG_W-1:0] SEG_E = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_F = 7'b0001110;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_VALID = 1'b1
  } state_t;

endpackage

// File: rtl/seg7_stability_filter.sv
// Glitch filter for the segment input: optional 2-flop synchronizer, sample
// register and a saturating counter of consecutive unchanged cycles.
// Optional feature: define SEG7_ENC_SYNC_EN to insert the synchronizer.
// Ports:
//   clk     in   system clock, rising edge
//   resetn  in   asynchronous active-low reset
//   din     in   raw active-low segment pattern
//   dout    out  registered pattern (seg_q)
//   stable  out  pattern in dout has been unchanged for STABLE_CYCLES cycles
import seg7_pkg::*;

module seg7_stability_filter #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [SEG_W-1:0] din,
  output logic [SEG_W-1:0] dout,
  output logic             stable
);

  logic [SEG_W-1:0] w_samp;
  logic [SEG_W-1:0] r_seg_q;
  logic [CNT_W-1:0] r_cnt;

`ifdef SEG7_ENC_SYNC_EN
  // Two-flop synchronizer; resets to blank so no digit appears out of reset.
  logic [SEG_W-1:0] r_sync1;
  logic [SEG_W-1:0] r_sync2;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync1 <= SEG_BLANK;
      r_sync2 <= SEG_BLANK;
    end else begin
      r_sync1 <= din;
      r_sync2 <= r_sync1;
    end
  end

  assign w_samp = r_sync2;
`else
  assign w_samp = din;
`endif

  // Sample register and saturating stability counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_seg_q <= SEG_BLANK;
      r_cnt   <= '0;
    end else begin
      r_seg_q <= w_samp;
      if (w_samp != r_seg_q) begin
        r_cnt <= '0;
      end else if (r_cnt != CNT_W'(STABLE_CYCLES)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign dout   = r_seg_q;
  assign stable = (r_cnt == CNT_W'(STABLE_CYCLES));

endmodule

// File: rtl/seg7_pattern_encoder.sv
// Converts a stable active-low 7-segment pattern back to a hex digit and
// emits each new non-blank pattern once over a valid/ready handshake.
// Optional feature: define SEG7_ENC_SYNC_EN to synchronize seg_in (+2 cycles).
// Ports:
//   clk          in   system clock, rising edge
//   resetn       in   asynchronous active-low reset
//   seg_in       in   active-low segment pattern, bit0=a .. bit6=g
//   out_ready    in   consumer accepts the digit when high with out_valid
//   out_valid    out  digit available, held until accepted
//   out_hex      out  decoded digit (0 when out_illegal)
//   out_illegal  out  pattern not in the digit table
//   busy         out  high while a digit is waiting for acceptance
import seg7_pkg::*;

module seg7_pattern_encoder #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [SEG_W-1:0] seg_in,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [HEX_W-1:0] out_hex,
  output logic             out_illegal,
  output logic             busy
);

  logic [SEG_W-1:0] w_seg_q;
  logic             w_stable;
  logic [HEX_W-1:0] w_dec_hex;
  logic             w_dec_illegal;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [SEG_W-1:0] r_last_pat;
  logic [SEG_W-1:0] w_last_pat_nxt;
  logic             r_valid;
  logic             w_valid_nxt;
  logic [HEX_W-1:0] r_hex;
  logic [HEX_W-1:0] w_hex_nxt;
  logic             r_illegal;
  logic             w_illegal_nxt;

  seg7_stability_filter #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .CNT_W         (CNT_W)
  ) u_filter (
    .clk    (clk),
    .resetn (resetn),
    .din    (seg_in),
    .dout   (w_seg_q),
    .stable (w_stable)
  );

  // Pattern-to-digit lookup; blank decodes as legal but is never emitted.
  always_comb begin
    w_dec_hex     = '0;
    w_dec_illegal = 1'b0;
    case (w_seg_q)
      SEG_0:     w_dec_hex = 4'h0;
      SEG_1:     w_dec_hex = 4'h1;
      SEG_2:     w_dec_hex = 4'h2;
      SEG_3:     w_dec_hex = 4'h3;
      SEG_4:     w_dec_hex = 4'h4;
      SEG_5:     w_dec_hex = 4'h5;
      SEG_6:     w_dec_hex = 4'h6;
      SEG_7:     w_dec_hex = 4'h7;
      SEG_8:     w_dec_hex = 4'h8;
      SEG_9:     w_dec_hex = 4'h9;
      SEG_A:     w_dec_hex = 4'hA;
      SEG_B:     w_dec_hex = 4'hB;
      SEG_C:     w_dec_hex = 4'hC;
      SEG_D:     w_dec_hex = 4'hD;
      SEG_E:     w_dec_hex = 4'hE;
      SEG_F:     w_dec_hex = 4'hF;
      SEG_BLANK: w_dec_hex = 4'h0;
      default:   w_dec_illegal = 1'b1;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_last_pat <= SEG_BLANK;
      r_valid    <= 1'b0;
      r_hex      <= '0;
      r_illegal  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_last_pat <= w_last_pat_nxt;
      r_valid    <= w_valid_nxt;
      r_hex      <= w_hex_nxt;
      r_illegal  <= w_illegal_nxt;
    end
  end

  // Next state: emit only when a stable pattern differs from the last one;
  // a stable blank re-arms so the same digit can be emitted again.
  always_comb begin
    w_state_nxt    = r_state;
    w_last_pat_nxt = r_last_pat;
    w_valid_nxt    = r_valid;
    w_hex_nxt      = r_hex;
    w_illegal_nxt  = r_illegal;
    case (r_state)
      S_IDLE: begin
        if (w_stable) begin
          if (w_seg_q == SEG_BLANK) begin
            w_last_pat_nxt = SEG_BLANK;
          end else if (w_seg_q != r_last_pat) begin
            w_last_pat_nxt = w_seg_q;
            w_hex_nxt      = w_dec_hex;
            w_illegal_nxt  = w_dec_illegal;
            w_valid_nxt    = 1'b1;
            w_state_nxt    = S_VALID;
          end
        end
      end
      S_VALID: begin
        if (out_ready) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign out_valid   = r_valid;
  assign out_hex     = r_hex;
  assign out_illegal = r_illegal;
  assign busy        = (r_state == S_VALID);

endmodule

// File: tb/tb_seg7_pattern_encoder.sv
// Scoreboard bench for seg7_pattern_encoder: stimulus pushes expected digits
// (value, illegal flag, cycle at which out_valid must rise); the monitor pops
// and compares on each accepted handshake.
module tb_seg7_pattern_encoder;

  localparam int STABLE = 4;
`ifdef SEG7_ENC_SYNC_EN
  localparam int LAT = STABLE + 4;
`else
  localparam int LAT = STABLE + 2;
`endif

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic [6:0] seg_in = 7'h7F;
  logic       out_ready = 1'b1;
  logic       out_valid;
  logic [3:0] out_hex;
  logic       out_illegal;
  logic       busy;

  seg7_pattern_encoder #(.STABLE_CYCLES(STABLE), .CNT_W(3)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .seg_in      (seg_in),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_hex     (out_hex),
    .out_illegal (out_illegal),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] hex;
    logic       ill;
    int         at;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: track rising edge of out_valid, compare on each handshake.
  logic prev_v = 1'b0;
  int   rise_cyc = 0;
  always @(negedge clk) begin
    if (out_valid === 1'b1 && prev_v !== 1'b1) rise_cyc = cyc;
    prev_v = out_valid;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_emit actual hex %0h illegal %0b required none (cycle %0d)",
                 out_hex, out_illegal, cyc);
      end else begin
        m_e = q.pop_front();
        chk("emit_hex", int'(out_hex), int'(m_e.hex));
        chk("emit_illegal", int'(out_illegal), int'(m_e.ill));
        if (m_e.at >= 0) chk("emit_latency", rise_cyc, m_e.at);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] hex, input logic ill, input int at);
    exp_t e;
    e.hex = hex;
    e.ill = ill;
    e.at  = at;
    q.push_back(e);
  endtask

  task automatic blank(input int n);
    seg_in = 7'b1111111;
    tick(n);
  endtask

  initial begin
    // Reset state
    #1 resetn = 1'b0;
    tick(2);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_hex", int'(out_hex), 0);
    chk("rst_illegal", int'(out_illegal), 0);
    chk("rst_busy", int'(busy), 0);
    resetn = 1'b1;
    blank(8);
    chk("rst_no_emit", q.size() + int'(out_valid), 0);

    // 1: '3' held 12 cycles, ready high -> one emission at latency LAT
    seg_in = 7'b0110000;
    push(4'h3, 1'b0, cyc + LAT);
    tick(12);
    chk("t1_queue", q.size(), 0);
    blank(8);

    // 2: '5' for 3 edges then '7' -> only '7'; '1' for 4 edges never emitted
    seg_in = 7'b0010010;
    tick(3);
    seg_in = 7'b1111000;
    push(4'h7, 1'b0, cyc + LAT);
    tick(10);
    chk("t2_queue", q.size(), 0);
    seg_in = 7'b1111001;
    tick(4);
    blank(10);
    // '1' for exactly 5 edges is the shortest hold that emits
    seg_in = 7'b1111001;
    push(4'h1, 1'b0, cyc + LAT);
    tick(5);
    blank(10);
    chk("t2_boundary_queue", q.size(), 0);

    // 3: '3' with ready low; input changes to '7' while waiting
    out_ready = 1'b0;
    seg_in = 7'b0110000;
    push(4'h3, 1'b0, cyc + LAT);
    tick(LAT + 1);
    chk("t3_valid_up", int'(out_valid), 1);
    seg_in = 7'b1111000;
    tick(20);
    chk("t3_valid_held", int'(out_valid), 1);
    chk("t3_hex_frozen", int'(out_hex), 3);
    chk("t3_busy", int'(busy), 1);
    out_ready = 1'b1;
    push(4'h7, 1'b0, cyc + 2);
    tick(6);
    chk("t3_queue", q.size(), 0);
    blank(8);

    // 4: same digit re-emits only after a stable blank; long hold emits once
    seg_in = 7'b0010010;
    push(4'h5, 1'b0, cyc + LAT);
    tick(10);
    blank(5);
    seg_in = 7'b0010010;
    push(4'h5, 1'b0, cyc + LAT);
    tick(50);
    chk("t4_queue", q.size(), 0);
    blank(8);

    // 5: illegal pattern flagged once with hex 0
    seg_in = 7'b1010101;
    push(4'h0, 1'b1, cyc + LAT);
    tick(20);
    chk("t5_queue", q.size(), 0);
    blank(8);

    // 6: async reset while a digit is pending drops it
    out_ready = 1'b0;
    seg_in = 7'b0011000;
    for (int i = 0; i < 20; i++) begin
      if (out_valid === 1'b1) break;
      tick(1);
    end
    chk("t6_valid_before", int'(out_valid), 1);
    chk("t6_hex_before", int'(out_hex), 9);
    #2 resetn = 1'b0;
    #1;
    chk("t6_valid_async", int'(out_valid), 0);
    chk("t6_busy_async", int'(busy), 0);
    seg_in = 7'b1111111;
    tick(2);
    resetn = 1'b1;
    chk("t6_busy_after", int'(busy), 0);
    out_ready = 1'b1;
    tick(20);
    chk("t6_no_stale", int'(out_valid), 0);
    chk("t6_queue", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
